// File: rtl/sega_pad_emulator_if.sv
// Connector-side bundle of the Sega MD pad emulator.
// The master side (console/host model and button source) drives SELECT and the
// button vector; the slave side (the emulator) drives the DB9 pin levels and
// the debug phase/mode observation signals.
interface sega_pad_emulator_if;
    logic        sel;      // DB9 pin 7 SELECT, asynchronous to clk
    logic [11:0] buttons;  // {M,X,Y,Z,S,A,C,B,U,D,L,R}, 1 = pressed
    logic        pad_p1;
    logic        pad_p2;
    logic        pad_p3;
    logic        pad_p4;
    logic        pad_p6;
    logic        pad_p9;
    logic [2:0]  phase;    // multiplex phase counter, debug only
    logic        mode6;    // XYZM phase served since the last timeout

    modport master (
        output sel, buttons,
        input  pad_p1, pad_p2, pad_p3, pad_p4, pad_p6, pad_p9, phase, mode6
    );

    modport slave (
        input  sel, buttons,
        output pad_p1, pad_p2, pad_p3, pad_p4, pad_p6, pad_p9, phase, mode6
    );
endinterface

// File: rtl/sega_pad_emulator.sv
// Sega MD 3/6-button pad emulator (pad end of the DB9 link).
// SELECT is synchronised, its falling edges step a 0..4 multiplex phase, and the
// six DB9 data pins are registered from the live button vector.
// Optional feature macro: SEGA_PAD_SIX_BUTTON_EN. When defined, the six-button
// phase sequence, idle timeout and mode6 flag are built; otherwise the block is
// a plain 3-button pad with phase and mode6 tied to 0.
module sega_pad_emulator #(
    parameter int CLK_MHZ    = 84,
    parameter int TIMEOUT_US = 1500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sega_pad_emulator_if.slave   pad
);

    typedef enum logic [2:0] {PH0, PH1, PH2, PH3, PH4} phase_t;

    typedef struct packed {
        logic m, x, y, z, s, a, c, b, u, d, l, r;
    } buttons_t;

    buttons_t   btn;
    logic       sel_m;
    logic       sel_s;
    phase_t     phase_nxt;
    logic [5:0] pins_nxt;   // {p1,p2,p3,p4,p6,p9}
    logic [5:0] pins_q;

    assign btn = pad.buttons;

    // Two-stage synchroniser for the asynchronous SELECT input.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_m <= 1'b1;
            sel_s <= 1'b1;
        end else begin
            sel_m <= pad.sel;
            sel_s <= sel_m;
        end
    end

`ifdef SEGA_PAD_SIX_BUTTON_EN
    localparam logic [19:0] IDLE_TERM = 20'(CLK_MHZ * TIMEOUT_US - 1);

    logic        sel_d;
    logic        sel_edge;
    logic        sel_fall;
    logic        timeout;
    logic [19:0] idle_cnt;
    phase_t      phase_q;
    phase_t      phase_base;
    logic        mode6_q;
    logic        mode6_nxt;

    assign sel_edge = sel_s ^ sel_d;
    assign sel_fall = sel_d & ~sel_s;
    assign timeout  = (idle_cnt == IDLE_TERM);

    // Edge history and saturating select-idle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_d    <= 1'b1;
            idle_cnt <= '0;
        end else begin
            sel_d <= sel_s;
            if (sel_edge)
                idle_cnt <= '0;
            else if (!timeout)
                idle_cnt <= idle_cnt + 20'd1;
        end
    end

    // Phase/mode6 next state: the timeout resets first, then a falling edge advances.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_base = timeout ? PH0 : phase_q;
        phase_nxt  = phase_base;
        if (sel_fall) begin
            case (phase_base)
                PH0:     phase_nxt = PH1;
                PH1:     phase_nxt = PH2;
                PH2:     phase_nxt = PH3;
                PH3:     phase_nxt = PH4;
                default: phase_nxt = PH1;
            endcase
        end
        mode6_nxt = mode6_q;
        if (timeout)
            mode6_nxt = 1'b0;
        if (sel_s && phase_nxt == PH3)
            mode6_nxt = 1'b1;
    end

    // Phase and mode6 state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH0;
            mode6_q <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            mode6_q <= mode6_nxt;
        end
    end

    assign pad.phase = phase_q;
    assign pad.mode6 = mode6_q;
`else
    assign phase_nxt = PH0;
    assign pad.phase = 3'd0;
    assign pad.mode6 = 1'b0;
`endif

    // Pin mapping from live buttons; uses the phase being entered this cycle so
    // the registered pins and the phase counter always agree.
    always_comb begin
        pins_nxt = {~btn.u, ~btn.d, ~btn.l, ~btn.r, ~btn.b, ~btn.c};
        if (sel_s) begin
            if (phase_nxt == PH3)
                pins_nxt = {~btn.z, ~btn.y, ~btn.x, ~btn.m, ~btn.b, ~btn.c};
        end else begin
            case (phase_nxt)
                PH3:     pins_nxt = {4'b0000, ~btn.a, ~btn.s};
                PH4:     pins_nxt = {4'b1111, ~btn.a, ~btn.s};
                default: pins_nxt = {~btn.u, ~btn.d, 2'b00, ~btn.a, ~btn.s};
            endcase
        end
    end

    // Output register for the DB9 pin levels (released = 1 in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pins_q <= 6'h3F;
        else
            pins_q <= pins_nxt;
    end

    assign pad.pad_p1 = pins_q[5];
    assign pad.pad_p2 = pins_q[4];
    assign pad.pad_p3 = pins_q[3];
    assign pad.pad_p4 = pins_q[2];
    assign pad.pad_p6 = pins_q[1];
    assign pad.pad_p9 = pins_q[0];

endmodule

// File: tb/tb_sega_pad_emulator.sv
// Directed bench for sega_pad_emulator. Expected pin words are {p1,p2,p3,p4,p6,p9}.
// A short timeout (TIMEOUT_US=40 at CLK_MHZ=8, 320 clocks) keeps the run brief.
// Timeout-related steps are compiled only when SEGA_PAD_SIX_BUTTON_EN is defined.
module tb_sega_pad_emulator;

    localparam int CLK_MHZ    = 8;
    localparam int TIMEOUT_US = 40;
    localparam int TERM       = CLK_MHZ * TIMEOUT_US - 1;
    localparam int LVL        = 4 * CLK_MHZ;   // 4 us per SELECT level

`ifdef SEGA_PAD_SIX_BUTTON_EN
    localparam bit          SIX       = 1'b1;
    localparam logic [11:0] FRAME_BTN = 12'h900;  // Z + M
`else
    localparam bit          SIX       = 1'b0;
    localparam logic [11:0] FRAME_BTN = 12'hF00;  // M, X, Y, Z
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sega_pad_emulator_if pad ();

    sega_pad_emulator #(
        .CLK_MHZ   (CLK_MHZ),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pad  (pad)
    );

    logic [5:0] pins;
    assign pins = {pad.pad_p1, pad.pad_p2, pad.pad_p3, pad.pad_p4, pad.pad_p6, pad.pad_p9};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Four SELECT pulses: low then high, checking pins/phase/mode6 on each level.
    task automatic run_frame(input string name);
        logic [5:0] lo_exp [4];
        logic [5:0] hi_exp [4];
        logic [2:0] ph_exp [4];
        logic       m6_exp [4];
`ifdef SEGA_PAD_SIX_BUTTON_EN
        lo_exp = '{6'h33, 6'h33, 6'h03, 6'h3F};
        hi_exp = '{6'h3F, 6'h3F, 6'h1B, 6'h3F};
        ph_exp = '{3'd1, 3'd2, 3'd3, 3'd4};
        m6_exp = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        lo_exp = '{4{6'h33}};
        hi_exp = '{4{6'h3F}};
        ph_exp = '{4{3'd0}};
        m6_exp = '{4{1'b0}};
`endif
        for (int i = 0; i < 4; i++) begin
            pad.sel = 1'b0;
            step(LVL);
            check($sformatf("%s_low%0d_pins", name, i + 1), 32'(pins), 32'(lo_exp[i]));
            check($sformatf("%s_low%0d_phase", name, i + 1), 32'(pad.phase), 32'(ph_exp[i]));
            pad.sel = 1'b1;
            step(LVL);
            check($sformatf("%s_high%0d_pins", name, i + 1), 32'(pins), 32'(hi_exp[i]));
            check($sformatf("%s_high%0d_mode6", name, i + 1), 32'(pad.mode6), 32'(m6_exp[i]));
        end
    endtask

    initial begin
        pad.sel     = 1'b1;
        pad.buttons = 12'h000;
        rst_n       = 1'b0;
        step(2);
        check("in_reset_pins", 32'(pins), 32'h3F);
        rst_n = 1'b1;
        step(3);
        check("reset_pins", 32'(pins), 32'h3F);
        check("reset_phase", 32'(pad.phase), 32'd0);
        check("reset_mode6", 32'(pad.mode6), 32'd0);

        // U + B with SELECT high: one-clock button latency.
        pad.buttons = 12'h018;
        step(1);
        check("ub_sel_high", 32'(pins), 32'h1D);

        // SELECT low with A: pins follow after three clocks.
        pad.sel     = 1'b0;
        pad.buttons = 12'h040;
        step(2);
        check("sel_fall_lat2", 32'(pins), 32'h3F);
        step(1);
        check("a_sel_low", 32'(pins), 32'h31);
        check("first_fall_phase", 32'(pad.phase), SIX ? 32'd1 : 32'd0);

`ifdef SEGA_PAD_SIX_BUTTON_EN
        // Idle boundary: phase survives TERM+3 clocks, clears on the next one.
        pad.sel = 1'b1;
        step(TERM + 3);
        check("pre_timeout_phase", 32'(pad.phase), 32'd1);
        step(1);
        check("timeout_phase", 32'(pad.phase), 32'd0);
`else
        pad.sel = 1'b1;
        step(LVL);
        check("three_btn_phase", 32'(pad.phase), 32'd0);
`endif

        pad.buttons = FRAME_BTN;
        run_frame("f1");

`ifdef SEGA_PAD_SIX_BUTTON_EN
        // Fifth falling edge without a timeout wraps 4 -> 1.
        pad.sel = 1'b0;
        step(LVL);
        check("wrap_phase", 32'(pad.phase), 32'd1);
        check("wrap_pins", 32'(pins), 32'h33);
        check("wrap_mode6", 32'(pad.mode6), 32'd1);

        // Long idle high: phase and mode6 cleared.
        pad.sel = 1'b1;
        step(TERM + 11);
        check("idle_phase", 32'(pad.phase), 32'd0);
        check("idle_mode6", 32'(pad.mode6), 32'd0);
        check("idle_pins", 32'(pins), 32'h3F);

        run_frame("f2");

        // Walk to phase 2 with SELECT low.
        pad.sel = 1'b0;
        step(LVL);
        pad.sel = 1'b1;
        step(LVL);
        pad.sel = 1'b0;
        step(LVL);
        check("setup_phase2", 32'(pad.phase), 32'd2);

        // Falling edge lands on the terminal cycle: timeout then edge gives 1.
        pad.sel = 1'b1;
        step(TERM + 1);
        pad.sel = 1'b0;
        step(3);
        check("fall_on_terminal_phase", 32'(pad.phase), 32'd1);
        check("fall_on_terminal_mode6", 32'(pad.mode6), 32'd0);

        // One clock earlier there is no timeout: 1 -> 2.
        pad.sel = 1'b1;
        step(TERM);
        pad.sel = 1'b0;
        step(3);
        check("fall_before_terminal_phase", 32'(pad.phase), 32'd2);

        // Enter phase 3 with SELECT low.
        pad.sel = 1'b1;
        step(LVL);
        pad.sel = 1'b0;
        step(LVL);
        check("mid3_phase", 32'(pad.phase), 32'd3);
        check("mid3_pins", 32'(pins), 32'h03);
`else
        pad.sel = 1'b0;
        step(LVL);
        check("three_btn_low_pins", 32'(pins), 32'h33);
        check("three_btn_low_phase", 32'(pad.phase), 32'd0);
`endif

        // Asynchronous reset mid-frame takes effect without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_pins", 32'(pins), 32'h3F);
        check("async_rst_phase", 32'(pad.phase), 32'd0);
        check("async_rst_mode6", 32'(pad.mode6), 32'd0);
        pad.sel = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(4);
        check("post_rst_pins", 32'(pins), 32'h3F);
        check("post_rst_phase", 32'(pad.phase), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
